// File: rtl/vt_pkg.sv
// Shared constants, FSM encoding and character helpers for the voltage text buffer.
// Every row renders as "CHnn: d.dddV" in 12 character cells.
package vt_pkg;

    localparam int NUM_CH  = 13;
    localparam int COLS    = 12;
    localparam int VREF_MV = 3300;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_V     = 8'h56;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_0     = 8'h30;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_SCALE = 3'd2;
    localparam logic [2:0] ST_BCD   = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    // One double-dabble correction step: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] adj;
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return adj;
    endfunction

    // Character for cell (row, col); digits holds the four BCD digits of the millivolt value.
    function automatic logic [7:0] cell_char(input logic [3:0]  row,
                                             input logic [3:0]  col,
                                             input logic [15:0] digits);
        logic [4:0] ch_num;
        logic [3:0] tens;
        logic [3:0] units;
        ch_num = 5'(row) + 5'd1;
        tens   = (ch_num >= 5'd10) ? 4'd1 : 4'd0;
        units  = (ch_num >= 5'd10) ? 4'(ch_num - 5'd10) : ch_num[3:0];
        case (col)
            4'd0:    return ASCII_C;
            4'd1:    return ASCII_H;
            4'd2:    return ASCII_0 + {4'd0, tens};
            4'd3:    return ASCII_0 + {4'd0, units};
            4'd4:    return ASCII_COLON;
            4'd5:    return ASCII_SPACE;
            4'd6:    return ASCII_0 + {4'd0, digits[15:12]};
            4'd7:    return ASCII_DOT;
            4'd8:    return ASCII_0 + {4'd0, digits[11:8]};
            4'd9:    return ASCII_0 + {4'd0, digits[7:4]};
            4'd10:   return ASCII_0 + {4'd0, digits[3:0]};
            4'd11:   return ASCII_V;
            default: return ASCII_SPACE;
        endcase
    endfunction

endpackage

// File: rtl/voltage_text_buffer_if.sv
// Sample handshake plus text-overlay read port of the voltage text buffer.
interface voltage_text_buffer_if;
    logic        sample_valid;
    logic        sample_ready;
    logic [3:0]  sample_ch;
    logic [11:0] sample_code;
    logic [7:0]  text_xy;
    logic [3:0]  text_line;
    logic [7:0]  char_pixel;
    logic        init_done;

    modport master (
        output sample_valid, sample_ch, sample_code, text_xy, text_line,
        input  sample_ready, char_pixel, init_done
    );

    modport slave (
        input  sample_valid, sample_ch, sample_code, text_xy, text_line,
        output sample_ready, char_pixel, init_done
    );
endinterface

// File: rtl/voltage_text_buffer_font_rom.sv
// 4096x8 synchronous glyph ROM, address {char, scanline}, one cycle latency.
// Only the characters the buffer can emit carry artwork; every other code renders blank.
module font_rom
    import vt_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] addr,
    output logic [7:0]  data
);

    logic [127:0] glyph;
    logic [127:0] shifted;

    always_comb begin
        case (addr[11:4])
            ASCII_C:     glyph = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
            ASCII_H:     glyph = 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
            ASCII_V:     glyph = 128'h0000_C6C6_C6C6_C6C6_C66C_3810_0000_0000;
            ASCII_COLON: glyph = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
            ASCII_DOT:   glyph = 128'h0000_0000_0000_0000_0000_1818_0000_0000;
            8'h30:       glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            8'h31:       glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            8'h32:       glyph = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            8'h33:       glyph = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            8'h34:       glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            8'h35:       glyph = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            8'h36:       glyph = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            8'h37:       glyph = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            8'h38:       glyph = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            8'h39:       glyph = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            default:     glyph = '0;
        endcase
        // Scanline 0 is the most significant byte of the glyph word.
        shifted = glyph << {addr[3:0], 3'b000};
    end

    always_ff @(posedge pclk) begin
        if (rst) data <= 8'h00;
        else     data <= shifted[127:120];
    end

endmodule

// File: rtl/voltage_text_buffer.sv
// Character RAM holding one "CHnn: d.dddV" line per ADC channel, refreshed from accepted
// samples (scale to millivolts, double-dabble to BCD, write the row) and read by the overlay.
module voltage_text_buffer #(
    parameter int NUM_CH  = vt_pkg::NUM_CH,
    parameter int COLS    = vt_pkg::COLS,
    parameter int VREF_MV = vt_pkg::VREF_MV
) (
    input  logic pclk,
    input  logic rst,
    voltage_text_buffer_if.slave bus
);
    import vt_pkg::*;

    localparam int CELLS = NUM_CH * COLS;

    logic [2:0]  state;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  bit_cnt;
    logic [11:0] code_q;
    logic [11:0] bin_sr;
    logic [15:0] bcd_sr;
    logic [23:0] product;
    logic [11:0] mv;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  ram [0:CELLS-1];
    logic [7:0]  rd_char;
    logic [3:0]  rd_line;

    assign bus.sample_ready = (state == ST_IDLE);
    assign bus.init_done    = (state != ST_INIT);

    assign product = 24'(code_q) * 24'(VREF_MV);
    assign mv      = 12'(product >> 12);

    // A write in flight on the reset edge is dropped so a reset really abandons the update.
    assign wr_en   = !rst && ((state == ST_INIT) || (state == ST_WRITE));
    assign wr_addr = 8'(row) * 8'(COLS) + 8'(col);
    assign wr_data = cell_char(row, col, (state == ST_WRITE) ? bcd_sr : 16'h0000);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state   <= ST_INIT;
            row     <= '0;
            col     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (col == 4'(COLS - 1)) begin
                        col <= '0;
                        if (row == 4'(NUM_CH - 1)) begin
                            row   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            row <= row + 4'd1;
                        end
                    end else begin
                        col <= col + 4'd1;
                    end
                end
                ST_IDLE: begin
                    if (bus.sample_valid && (bus.sample_ch < 4'(NUM_CH))) begin
                        row   <= bus.sample_ch;
                        state <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    bit_cnt <= '0;
                    state   <= ST_BCD;
                end
                ST_BCD: begin
                    if (bit_cnt == 4'd11) begin
                        col   <= '0;
                        state <= ST_WRITE;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_WRITE: begin
                    if (col == 4'(COLS - 1)) begin
                        col   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        col <= col + 4'd1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // NOTE: RAM and conversion datapath carry no reset; INIT rewrites every cell and each
    // conversion reloads its shift registers before they are used.
    always_ff @(posedge pclk) begin
        if ((state == ST_IDLE) && bus.sample_valid) code_q <= bus.sample_code;
        if (state == ST_SCALE) begin
            bin_sr <= mv;
            bcd_sr <= '0;
        end else if (state == ST_BCD) begin
            {bcd_sr, bin_sr} <= {bcd_adjust(bcd_sr), bin_sr} << 1;
        end
    end

    always_ff @(posedge pclk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
    end

    // Reading in the same edge as a write returns the character stored before that write.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_char <= 8'h00;
            rd_line <= '0;
        end else begin
            rd_char <= (bus.text_xy < 8'(CELLS)) ? ram[bus.text_xy] : ASCII_SPACE;
            rd_line <= bus.text_line;
        end
    end

    font_rom u_font_rom (
        .pclk (pclk),
        .rst  (rst),
        .addr ({rd_char, rd_line}),
        .data (bus.char_pixel)
    );

endmodule
